module_spi_ctrl: RTL and testbench
==================================

# module_spi_ctrl

SPI master sequencer that sits beside the register-file memory: it reads transmit words from the memory's read port, shifts them out on MOSI in SPI mode 0, captures MISO, and writes each received word back to the same memory address through the memory's write port. One `start_i` pulse runs a burst of `n_tx_i` words from addresses 1..`n_tx_i`. Chip-select stays asserted for the whole burst. Address 0 is the hardwired-zero entry and is never used.

## Interface
- `DIV`, default 4: SCLK half-period in `clk_i` cycles; legal range ≥1.
- Data width `W` and address width `N` come from the shared package types `bits_width` and `bitsh_t`.

Ports:
- `clk_i`  in  1  system clock; all flops on the rising edge.
- `rst_n_i`  in  1  reset, asynchronous assert, active-low.
- `start_i`  in  1  burst request; sampled only in IDLE.
- `n_tx_i`  in  N  number of words in the burst; latched on accepted start.
- `busy_o`  out  1  high from the cycle after accept until DONE completes.
- `done_o`  out  1  one-cycle pulse at end of burst.
- `cnt_tx_o`  out  N  words completed in the current/last burst.
- `addr_rs1_o`  out  N  memory read address.
- `rs1_i`  in  W  memory read data; combinational from `addr_rs1_o`.
- `we_o`  out  1  memory write enable.
- `addr_rd_o`  out  N  memory write address.
- `data_o`  out  W  memory write data.
- `sclk_o`  out  1  SPI clock; idles low.
- `cs_n_o`  out  1  SPI chip select, active-low.
- `mosi_o`  out  1  serial out, MSB first.
- `miso_i`  in  1  serial in.

## Operation
- Reset values:
  - `cs_n_o`=1.
  - `sclk_o`=0, `mosi_o`=0, `we_o`=0, `done_o`=0, `busy_o`=0.
  - `cnt_tx_o`=0, `addr_rs1_o`=0, `addr_rd_o`=0, `data_o`=0.
  - State is IDLE.
- FSM states: IDLE, LOAD, SHIFT, STORE, DONE.
- **IDLE**
  - `start_i` with `n_tx_i`≠0: latch `n_tx_i`, set index=1, clear `cnt_tx_o`, go to LOAD.
  - `start_i` with `n_tx_i`=0: clear `cnt_tx_o`, go to DONE; CS is never asserted.
- **LOAD**
  - Drive `addr_rs1_o`=index and load `rs1_i` into the shift register.
  - `cs_n_o` goes to 0 if not already low.
  - `mosi_o` is driven with the word's MSB, then go to SHIFT.
- **SHIFT**
  - A half-period counter toggles `sclk_o` every `DIV` cycles.
  - On each 0→1 toggle: sample `miso_i` into the receive register LSB (left shift).
  - On each 1→0 toggle: shift the next TX bit onto `mosi_o`.
  - The W-th falling toggle exits to STORE, with `sclk_o` back at 0.
- **STORE**
  - One cycle with `we_o`=1, `addr_rd_o`=index, `data_o`=received word.
  - `cnt_tx_o` increments.
  - If index = latched n_tx: go to DONE. Otherwise increment index and go to LOAD.
- **DONE**
  - `cs_n_o`=1 and `done_o`=1 for one cycle, then return to IDLE.
- `start_i` outside IDLE is ignored; it is not queued.
- Index range is 1..2^N−1. It never wraps and never targets address 0.
- Asserting `rst_n_i` mid-burst immediately forces all reset values. No partial-word write occurs.
- `miso_i` is used directly. Synchronisation is the pad wrapper's job.

## Timing
- Accept: `start_i` high in IDLE at edge k → LOAD at k+1.
- Per word: LOAD 1 cycle + SHIFT 2·DIV·W cycles + STORE 1 cycle.
- Burst of n words: `done_o` is high n·(2·DIV·W+2) cycles after LOAD is first entered.
- `n_tx_i`=0: `done_o` is high the cycle after accept.
- The first SCLK rising edge occurs DIV cycles after SHIFT entry.
- MOSI is stable ≥DIV cycles before every rising edge.
- `cs_n_o` falls the cycle LOAD is first entered and stays low across STORE/LOAD gaps between words.
- `busy_o` is high in LOAD, SHIFT, STORE and DONE.

## Structure
- Add to `pkg_global`:
  - `spi_state_t` enum (IDLE, LOAD, SHIFT, STORE, DONE).
  - Reuse `bitsh_t` and `bits_width`.
- Sub-module `module_spi_sclk_gen`:
  - Inputs: `DIV` counter and enable.
  - Outputs: `sclk_o` plus one-cycle `rise`/`fall` strobes.
  - Resets and holds low when disabled.

## Test plan
1. Reset with all inputs toggling → every output at its reset value; `cs_n_o`=1; no `we_o`.
2. W=8, DIV=4, mem[1]=0xA5, MISO looped to MOSI, `n_tx_i`=1:
   - MOSI bits 1,0,1,0,0,1,0,1 on rising edges.
   - `we_o` at addr 1 with data 0xA5.
   - `done_o` 66 cycles after LOAD; `cnt_tx_o`=1.
3. `n_tx_i`=0 → `done_o` the next cycle; `cs_n_o` never low; `we_o` never high.
4. `n_tx_i`=3, `miso_i` tied 1 → writes 0xFF to addresses 1, 2, 3 in order; `cs_n_o` continuously low; `cnt_tx_o`=3.
5. `start_i` pulsed during SHIFT is ignored (`cnt_tx_o` unchanged). `rst_n_i` low mid-SHIFT → `cs_n_o`=1 and `we_o`=0 immediately; no write to memory.
6. DIV=1, `n_tx_i`=2 → SCLK toggles every cycle; two writes; `done_o` at 2·(16+2) cycles.

Source files
------------

// File: rtl/module_spi_ctrl_pkg.sv
// Shared types for the register-file SPI sequencer: data word, address, and FSM state.
package pkg_global;

   localparam int bits_width  = 8;
   localparam int bitsh_width = 5;
   localparam int bit_cnt_w   = $clog2(bits_width);

   typedef logic [bits_width-1:0]  bits_t;
   typedef logic [bitsh_width-1:0] bitsh_t;
   typedef logic [bit_cnt_w-1:0]   bit_cnt_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      STORE = 3'd3,
      DONE  = 3'd4
   } spi_state_t;

endpackage

// File: rtl/module_spi_ctrl_sclk_gen.sv
// SPI mode-0 clock generator: toggles every DIV enabled cycles and flags each edge one cycle early.
module module_spi_sclk_gen #(
   parameter int DIV = 4
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic en_i,
   output logic sclk_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sclk_q, sclk_d;
   logic          tick;

   // The strobes mark the cycle whose closing edge toggles sclk.
   assign tick   = en_i && (cnt_q == CW'(DIV - 1));
   assign rise_o = tick && !sclk_q;
   assign fall_o = tick && sclk_q;
   assign sclk_o = sclk_q;

   always_comb begin
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      if (!en_i) begin
         cnt_d  = '0;
         sclk_d = 1'b0;
      end else if (tick) begin
         cnt_d  = '0;
         sclk_d = !sclk_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/module_spi_ctrl.sv
// SPI master burst sequencer: reads words 1..n from the register file, shifts them out
// in mode 0, and writes each received word back to the same address.
module module_spi_ctrl
   import pkg_global::*;
#(
   parameter int DIV = 4
) (
   input  logic   clk_i,
   input  logic   rst_n_i,
   input  logic   start_i,
   input  bitsh_t n_tx_i,
   output logic   busy_o,
   output logic   done_o,
   output bitsh_t cnt_tx_o,
   output bitsh_t addr_rs1_o,
   input  bits_t  rs1_i,
   output logic   we_o,
   output bitsh_t addr_rd_o,
   output bits_t  data_o,
   output logic   sclk_o,
   output logic   cs_n_o,
   output logic   mosi_o,
   input  logic   miso_i
);

   spi_state_t state_q, state_d;
   bitsh_t     idx_q, idx_d;
   bitsh_t     n_q, n_d;
   bitsh_t     cnt_q, cnt_d;
   bits_t      tx_q, tx_d;
   bits_t      rx_q, rx_d;
   bit_cnt_t   bit_q, bit_d;
   logic       mosi_q, mosi_d;
   logic       rise, fall;

   module_spi_sclk_gen #(.DIV(DIV)) u_sclk (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .en_i   (state_q == SHIFT),
      .sclk_o (sclk_o),
      .rise_o (rise),
      .fall_o (fall)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      bit_d   = bit_q;
      mosi_d  = mosi_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               cnt_d = '0;
               if (n_tx_i != '0) begin
                  n_d     = n_tx_i;
                  idx_d   = bitsh_t'(1);
                  state_d = LOAD;
               end else begin
                  state_d = DONE;
               end
            end
         end
         LOAD: begin
            tx_d    = rs1_i;
            mosi_d  = rs1_i[bits_width-1];
            bit_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (rise) rx_d = {rx_q[bits_width-2:0], miso_i};
            if (fall) begin
               tx_d   = {tx_q[bits_width-2:0], 1'b0};
               mosi_d = tx_q[bits_width-2];
               if (bit_q == bit_cnt_t'(bits_width - 1)) state_d = STORE;
               else                                     bit_d   = bit_q + bit_cnt_t'(1);
            end
         end
         STORE: begin
            cnt_d = cnt_q + bitsh_t'(1);
            // idx never exceeds the latched count, so it cannot wrap back to address 0.
            if (idx_q == n_q) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + bitsh_t'(1);
               state_d = LOAD;
            end
         end
         DONE: begin
            mosi_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         n_q     <= '0;
         cnt_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         bit_q   <= '0;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         bit_q   <= bit_d;
         mosi_q  <= mosi_d;
      end
   end

   // Decoded from the state register so reset forces them off without waiting for a clock.
   assign busy_o     = (state_q != IDLE);
   assign done_o     = (state_q == DONE);
   assign we_o       = (state_q == STORE);
   assign cs_n_o     = !((state_q == LOAD) || (state_q == SHIFT) || (state_q == STORE));
   assign cnt_tx_o   = cnt_q;
   assign addr_rs1_o = idx_q;
   assign addr_rd_o  = idx_q;
   assign data_o     = rx_q;
   assign mosi_o     = mosi_q;

endmodule

// File: tb/tb_module_spi_ctrl.sv
// Bench for module_spi_ctrl: table-driven bursts on a DIV=4 instance, corner sequences,
// and a DIV=1 instance; all memory writes go through an expected-write scoreboard.
module tb_module_spi_ctrl;
   import pkg_global::*;

   localparam int AW = bitsh_width + bits_width;

   logic clk, rst_n;
   logic start_a, start_b;
   bitsh_t n_tx;
   logic [1:0] miso_mode;   // 0: tied 0, 1: tied 1, 2: loopback from mosi
   bits_t mem [32];

   logic   busy_a, done_a, we_a, sclk_a, cs_n_a, mosi_a, miso_a;
   bitsh_t cnt_a, addr_rs1_a, addr_rd_a;
   bits_t  rs1_a, data_a;
   logic   busy_b, done_b, we_b, sclk_b, cs_n_b, mosi_b, miso_b;
   bitsh_t cnt_b, addr_rs1_b, addr_rd_b;
   bits_t  rs1_b, data_b;

   logic [AW-1:0] exp_a_q[$];
   logic [AW-1:0] exp_b_q[$];
   bits_t mosi_cap;
   int n_tests = 0;
   int n_fail  = 0;

   assign rs1_a  = mem[addr_rs1_a];
   assign rs1_b  = mem[addr_rs1_b];
   assign miso_a = (miso_mode == 2'd2) ? mosi_a : miso_mode[0];
   assign miso_b = mosi_b;

   module_spi_ctrl #(.DIV(4)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start_a), .n_tx_i(n_tx),
      .busy_o(busy_a), .done_o(done_a), .cnt_tx_o(cnt_a), .addr_rs1_o(addr_rs1_a),
      .rs1_i(rs1_a), .we_o(we_a), .addr_rd_o(addr_rd_a), .data_o(data_a),
      .sclk_o(sclk_a), .cs_n_o(cs_n_a), .mosi_o(mosi_a), .miso_i(miso_a)
   );

   module_spi_ctrl #(.DIV(1)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start_b), .n_tx_i(n_tx),
      .busy_o(busy_b), .done_o(done_b), .cnt_tx_o(cnt_b), .addr_rs1_o(addr_rs1_b),
      .rs1_i(rs1_b), .we_o(we_b), .addr_rd_o(addr_rd_b), .data_o(data_b),
      .sclk_o(sclk_b), .cs_n_o(cs_n_b), .mosi_o(mosi_b), .miso_i(miso_b)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: every memory write must match the head of its instance's queue
   task automatic sb_check(input bit inst_b, input logic [AW-1:0] got);
      logic [AW-1:0] e;
      n_tests++;
      if ((inst_b ? exp_b_q.size() : exp_a_q.size()) == 0) begin
         n_fail++;
         $display("FAIL sb_write inst=%0d: got addr/data %0h expected no write", inst_b, got);
      end else begin
         e = inst_b ? exp_b_q.pop_front() : exp_a_q.pop_front();
         if (got !== e) begin
            n_fail++;
            $display("FAIL sb_write inst=%0d: got addr/data %0h expected %0h", inst_b, got, e);
         end
      end
   endtask

   always @(negedge clk) begin
      if (we_a) sb_check(1'b0, {addr_rd_a, data_a});
      if (we_b) sb_check(1'b1, {addr_rd_b, data_b});
   end

   always @(posedge sclk_a) mosi_cap = {mosi_cap[bits_width-2:0], mosi_a};

   // driver: pulse start, then follow the burst until done_o (bounded)
   task automatic run_burst(input bit use_b, input bitsh_t n, output int lat,
                            output bit cs_low_seen, output bit cs_gap,
                            output bit busy_bad, output bit sclk_bad);
      @(negedge clk);
      if (use_b) start_b = 1'b1; else start_a = 1'b1;
      n_tx = n;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      lat = 0; cs_low_seen = 0; cs_gap = 0; busy_bad = 0; sclk_bad = 0;
      for (int c = 1; c <= 2000; c++) begin
         logic d_s, cs_s, b_s;
         d_s  = use_b ? done_b : done_a;
         cs_s = use_b ? cs_n_b : cs_n_a;
         b_s  = use_b ? busy_b : busy_a;
         if (!b_s) busy_bad = 1;
         if (!cs_s) cs_low_seen = 1;
         else if (cs_low_seen && !d_s) cs_gap = 1;
         // DIV=1: first word SHIFT spans cycles 2..17, sclk high on odd cycles
         if (use_b && c >= 2 && c <= 17 && (sclk_b != c[0])) sclk_bad = 1;
         if (d_s) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_idle_a(input string name);
      check({name, "_ctl"}, {cs_n_a, we_a, busy_a, done_a, sclk_a, mosi_a}, 6'b100000);
   endtask

   typedef struct {
      bitsh_t     n;
      logic [1:0] mode;
      bitsh_t     exp_cnt;
      int         exp_lat;   // cycles from accept edge to done_o: 1 + n*(2*DIV*W+2)
   } vec_t;

   vec_t vecs[5];
   int   lat;
   bit   cs_low, cs_gap, busy_bad, sclk_bad;
   bits_t d;

   initial begin
      vecs[0] = '{n: 5'd1, mode: 2'd2, exp_cnt: 5'd1, exp_lat: 67};
      vecs[1] = '{n: 5'd0, mode: 2'd1, exp_cnt: 5'd0, exp_lat: 1};
      vecs[2] = '{n: 5'd3, mode: 2'd1, exp_cnt: 5'd3, exp_lat: 199};
      vecs[3] = '{n: 5'd2, mode: 2'd0, exp_cnt: 5'd2, exp_lat: 133};
      vecs[4] = '{n: 5'd5, mode: 2'd2, exp_cnt: 5'd5, exp_lat: 331};
      for (int i = 0; i < 32; i++) mem[i] = bits_t'($urandom_range(0, 255));
      mem[1] = 8'hA5;
      mosi_cap = '0;

      // reset with inputs toggling
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; n_tx = '0; miso_mode = 2'd0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         start_a   = 1'($urandom_range(0, 1));
         start_b   = 1'($urandom_range(0, 1));
         n_tx      = bitsh_t'($urandom_range(0, 31));
         miso_mode = 2'($urandom_range(0, 1));
         @(negedge clk);
         check_idle_a("reset_a");
         check("reset_a_bus", {cnt_a, addr_rs1_a, addr_rd_a, data_a}, 0);
      end
      check("reset_b_ctl", {cs_n_b, we_b, busy_b, done_b, sclk_b, mosi_b}, 6'b100000);
      check("reset_b_bus", {cnt_b, addr_rs1_b, addr_rd_b, data_b}, 0);
      start_a = 1'b0; start_b = 1'b0; n_tx = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // table-driven bursts on the DIV=4 instance
      for (int i = 0; i < 5; i++) begin
         miso_mode = vecs[i].mode;
         for (int k = 1; k <= int'(vecs[i].n); k++) begin
            d = (vecs[i].mode == 2'd2) ? mem[k] : {bits_width{vecs[i].mode[0]}};
            exp_a_q.push_back({bitsh_t'(k), d});
         end
         run_burst(1'b0, vecs[i].n, lat, cs_low, cs_gap, busy_bad, sclk_bad);
         check($sformatf("v%0d_done_latency", i), lat, vecs[i].exp_lat);
         check($sformatf("v%0d_cnt_tx", i), cnt_a, vecs[i].exp_cnt);
         check($sformatf("v%0d_busy_held", i), busy_bad, 0);
         check($sformatf("v%0d_cs_low_seen", i), cs_low, vecs[i].n != 0);
         check($sformatf("v%0d_cs_continuous", i), cs_gap, 0);
         if (i == 0) check("v0_mosi_bits", mosi_cap, 8'hA5);
         @(negedge clk);
         check_idle_a($sformatf("v%0d_after", i));
         check($sformatf("v%0d_sb_drained", i), exp_a_q.size(), 0);
      end

      // start pulsed during SHIFT is ignored
      miso_mode = 2'd1;
      exp_a_q.push_back({bitsh_t'(1), 8'hFF});
      fork
         run_burst(1'b0, 5'd1, lat, cs_low, cs_gap, busy_bad, sclk_bad);
         begin
            repeat (12) @(negedge clk);
            start_a = 1'b1;
            n_tx = 5'd3;
            @(negedge clk);
            start_a = 1'b0;
         end
      join
      check("ign_start_latency", lat, 67);
      check("ign_start_cnt_tx", cnt_a, 1);
      repeat (5) @(negedge clk);
      check_idle_a("ign_start_after");
      check("ign_start_sb_drained", exp_a_q.size(), 0);

      // asynchronous reset mid-SHIFT: no write, outputs forced at once
      @(negedge clk);
      start_a = 1'b1;
      n_tx = 5'd2;
      @(negedge clk);
      start_a = 1'b0;
      repeat (20) @(negedge clk);
      check("mid_shift_cs_low", cs_n_a, 0);
      #2 rst_n = 1'b0;
      #1;
      check_idle_a("mid_reset");
      check("mid_reset_cnt", cnt_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (150) @(negedge clk);
      check_idle_a("mid_reset_after");

      // DIV=1 instance, two words looped back
      exp_b_q.push_back({bitsh_t'(1), mem[1]});
      exp_b_q.push_back({bitsh_t'(2), mem[2]});
      run_burst(1'b1, 5'd2, lat, cs_low, cs_gap, busy_bad, sclk_bad);
      check("div1_done_latency", lat, 37);
      check("div1_cnt_tx", cnt_b, 2);
      check("div1_sclk_every_cycle", sclk_bad, 0);
      check("div1_cs_continuous", cs_gap, 0);
      @(negedge clk);
      check("div1_sb_drained", exp_b_q.size(), 0);
      check("final_sb_a_drained", exp_a_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
